riscv32_mem_arbiter: RTL
========================

# riscv32_mem_arbiter

Two-requester memory arbiter between the riscv32 engine's instruction-fetch port and its data port (cacheable or non-cacheable side, muxed upstream) and a single shared backing-memory bus. One transaction is outstanding at a time. Data requests have priority, with a starvation guard so fetch always progresses. A timeout converts a dead slave into a completed, error-flagged transaction.

## Interface
- STARVE_LIMIT, 4: max consecutive data grants while a fetch request is pending (1..15)
- TIMEOUT, 64: cycles in BUSY without mem_ack before abort (1..255)
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, reset asynchronous and active-high
- i_rden  in  1  fetch request, held until i_rdhit
- i_rdaddr  in  32  fetch address; stable while i_rden is high
- i_rdhit  out  1  one-cycle pulse: fetch complete, i_rddata valid
- i_rddata  out  32  fetch data; held until the next i-side completion
- d_rden / d_wren  in  1 / 1  data read / write request, held until d_rdwrhit; never both high
- d_rdwraddr  in  32  data address
- d_wr_be  in  4  write byte enables
- d_wrdata  in  32  write data
- d_rdwrhit  out  1  one-cycle pulse: data transaction complete
- d_rddata  out  32  read data; 0 after a write
- mem_req  out  1  bus request, held until mem_ack or timeout
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables; 4'hF for reads
- mem_wdata  out  32  write data; 0 for reads
- mem_ack  in  1  slave completion; sampled only when mem_req is 1
- mem_rdata  in  32  read data, valid with mem_ack
- bus_err  out  1  one-cycle pulse together with the hit of a timed-out transaction

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: if the data request (d_rden|d_wren) is present and starve_cnt < STARVE_LIMIT, or i_rden is low -> BUSY_D. Else if i_rden -> BUSY_I. Else stay in IDLE.
- Entering BUSY_x registers mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata from the granted port. All mem_* outputs are registered.
- starve_cnt (4 bits):
  - A data grant while i_rden=1 increments it.
  - Any fetch grant clears it.
  - A data grant with i_rden=0 clears it.
  - Saturates at STARVE_LIMIT.
- BUSY_x:
  - tmo_cnt increments each cycle.
  - mem_ack=1 -> clear mem_req, capture mem_rdata (or 0 for a write) into the granted port's rddata, go to RESP.
  - tmo_cnt reaches TIMEOUT-1 without ack -> same transition with data 0 and err flag set.
- RESP: pulse the granted port's hit for one cycle; pulse bus_err if flagged; clear tmo_cnt; go to IDLE. Requests are ignored in RESP.
- The requester drops or changes its request in the RESP cycle. A request still high in the following IDLE cycle is treated as new.
- mem_ack while mem_req=0 is ignored.
- Reset, anytime, including mid-transaction:
  - State goes to IDLE; starve_cnt and tmo_cnt go to 0.
  - All outputs go to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, i_rdhit, i_rddata, d_rdwrhit, d_rddata, bus_err.
  - In-flight transaction is dropped without a hit; a late ack is ignored.

## Timing
- Request first seen in IDLE at cycle T. mem_req=1 at T+1.
- Ack at T+1+k (k≥0; a same-cycle combinational ack is legal). Hit at T+2+k; next grant decision at T+3+k.
- Minimum request-to-hit latency is 2 cycles. Minimum issue interval is 3 cycles per transaction.
- Timeout: with no ack, mem_req is high for exactly TIMEOUT cycles; hit and bus_err occur at T+1+TIMEOUT.
- Simultaneous data and fetch requests in IDLE: data wins unless starve_cnt == STARVE_LIMIT.
- mem_* outputs are stable for the whole BUSY period.

## Test plan
- Single fetch, slave acks at k=0, mem_rdata=0x0000_0013 -> mem_req high 1 cycle with mem_addr=0x100 (i_rdaddr=0x102); i_rdhit at T+2; i_rddata=0x13; mem_be=F.
- Data write, addr 0x2000, be=4'b0011, wdata=0xA5A5_1234, ack after 3 cycles -> mem_we=1, mem_be=3, d_rdwrhit at T+5, d_rddata=0, no i_rdhit.
- Both requesters held continuously, STARVE_LIMIT=4, ack k=0 -> grant order D,D,D,D,I,D,D,D,D,I; fetch completes every 5th transaction.
- Data read, slave never acks, TIMEOUT=64 -> mem_req high exactly 64 cycles; d_rdwrhit and bus_err both pulse at T+65; d_rddata=0; the next request proceeds normally.
- rst asserted 2 cycles into a BUSY_D read, ack arrives during rst and the cycle after -> no d_rdwrhit, all outputs 0, state IDLE; a fresh fetch after rst completes in 2 cycles.
- mem_ack pulsed in IDLE with no requests -> no hit, no state change.

Source files
------------

// File: rtl/riscv32_mem_arbiter.sv
// riscv32_mem_arbiter: fetch/data arbiter onto one shared memory bus with starvation guard and slave timeout
module riscv32_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rden,
  input  logic [31:0] i_rdaddr,
  output logic        i_rdhit,
  output logic [31:0] i_rddata,
  input  logic        d_rden,
  input  logic        d_wren,
  input  logic [31:0] d_rdwraddr,
  input  logic [3:0]  d_wr_be,
  input  logic [31:0] d_wrdata,
  output logic        d_rdwrhit,
  output logic [31:0] d_rddata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  state_t      r_state;
  logic [3:0]  r_starve;
  logic [7:0]  r_tmo;
  logic        w_grant_d;
  logic        w_we;
  logic        w_tmo;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  // data wins unless the fetch side has already been passed over STARVE_LIMIT times
  assign w_grant_d = (d_rden | d_wren) & ((r_starve < 4'(STARVE_LIMIT)) | ~i_rden);
  assign w_we      = w_grant_d & d_wren;
  assign w_addr    = w_grant_d ? d_rdwraddr : i_rdaddr;
  assign w_tmo     = r_tmo == 8'(TIMEOUT - 1);
  assign w_rdata   = (mem_ack && !mem_we) ? mem_rdata : 32'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_starve  <= 4'd0;
      r_tmo     <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      i_rdhit   <= 1'b0;
      i_rddata  <= 32'd0;
      d_rdwrhit <= 1'b0;
      d_rddata  <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      i_rdhit   <= 1'b0;
      d_rdwrhit <= 1'b0;
      bus_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d || i_rden) begin
            r_state   <= w_grant_d ? BUSY_D : BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= w_we;
            mem_addr  <= w_addr & ~32'h3;
            mem_be    <= w_we ? d_wr_be : 4'hF;
            mem_wdata <= w_we ? d_wrdata : 32'd0;
            r_starve  <= (w_grant_d && i_rden) ? r_starve + 4'd1 : 4'd0;
          end
        end
        BUSY_I, BUSY_D: begin
          r_tmo <= r_tmo + 8'd1;
          // a timeout completes the transaction like an ack, but with zero data and an error flag
          if (mem_ack || w_tmo) begin
            r_state <= RESP;
            mem_req <= 1'b0;
            bus_err <= ~mem_ack;
            if (r_state == BUSY_I) begin
              i_rdhit  <= 1'b1;
              i_rddata <= w_rdata;
            end else begin
              d_rdwrhit <= 1'b1;
              d_rddata  <= w_rdata;
            end
          end
        end
        default: begin
          r_tmo   <= 8'd0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
